tt_factory_seq_checker: RTL
===========================

Name: tt_factory_seq_checker

Overview:
- Downstream consumer of the factory-test counter outputs: samples an 8-bit bus that should carry a free-running up- or down-counter.
- Locks onto the sequence, then counts deviations per cycle.
- Reports lock/pass/error status for the tester or a companion test tile.
- Pure checker; never drives the DUT.

Parameters:
- LOCK_CNT, 4: consecutive correct steps required to declare lock (1..15).
- LOSS_CNT, 8: consecutive mismatches in LOCKED that force re-acquire (1..255).
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  clock; sampling on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  check enable; low forces IDLE.
- dir  input  1  expected direction: 1 = increment (+1), 0 = decrement (-1).
- clr  input  1  synchronous clear of err_cnt, chk_cnt, lost; highest priority after reset.
- data_in  input  8  observed counter bus.
- locked  output  1  high while in LOCKED.
- pass  output  1  locked && err_cnt==0 && !lost.
- lost  output  1  sticky: lock was lost at least once since reset/clr.
- err_cnt  output  ERR_W  mismatches seen in LOCKED, saturating at all-ones.
- chk_cnt  output  16  samples compared in LOCKED, saturating at 16'hFFFF.

Behaviour:
- Reset (rst_n low, async): state=IDLE; locked=0, pass=0, lost=0, err_cnt=0, chk_cnt=0; internal expected=0, run counters=0.
- Step function: nxt(x) = dir ? x+1 : x-1, modulo 256. 8'hFF+1=8'h00 and 8'h00-1=8'hFF are correct steps, not errors.
- State IDLE:
  - Counters hold.
  - en=1 -> ACQUIRE. The first cycle in ACQUIRE seeds expected=nxt(data_in), match_run=0.
- State ACQUIRE:
  - data_in==expected: match_run+1, expected=nxt(data_in).
  - Otherwise: match_run=0, expected=nxt(data_in) (reseed).
  - When match_run reaches LOCK_CNT on a matching sample -> LOCKED on the next edge. locked rises the cycle after the LOCK_CNT-th match.
  - err_cnt and chk_cnt do not change in ACQUIRE.
- State LOCKED (flywheel):
  - Every cycle: chk_cnt+1 (saturating), expected=nxt(expected). The prediction is never reseeded from data_in.
  - Mismatch: err_cnt+1 (saturating), miss_run+1.
  - Match: miss_run=0.
  - miss_run reaching LOSS_CNT -> ACQUIRE, lost=1, miss_run=0, reseed on next sample.
  - A single corrupted sample costs exactly 1 error. A permanent slip costs LOSS_CNT errors, then re-acquire.
- dir change while LOCKED: treated as data. Mismatches accrue until loss. No implicit re-acquire.
- en=0 from any state -> IDLE next edge; locked=0; err_cnt/chk_cnt/lost hold.
- clr=1: clears err_cnt, chk_cnt, lost that cycle. State and prediction are unaffected.
- clr coincident with an error event: clear wins; the counter ends at 0.
- All outputs are registered except pass (combinational from registered state).
- Re-enable after IDLE re-acquires from scratch; counters keep accumulating unless clr.

Optional Feature:
- Macro SEQ_CHK_CAPTURE_EN.
- Defined:
  - Extra outputs first_exp[7:0], first_act[7:0], first_vld.
  - On the first LOCKED mismatch since reset/clr, these capture the expected and observed values and set first_vld=1.
  - Later mismatches do not overwrite.
  - clr clears all three.
  - Reset value of all three is 0.
- Undefined: ports still present, tied to 0; no capture registers.

Test Plan:
- Up-count 8'h00..: en=1, dir=1 -> locked=1 at cycle 1+LOCK_CNT+1 after en; run 300 cycles through FF->00 wrap -> err_cnt=0, pass=1, chk_cnt equals cycles in LOCKED.
- Down-count with wrap: start 8'h02, dir=0, lock, run through 00->FF -> err_cnt=0, lost=0.
- Single glitch: locked up-count, replace one sample 8'h40 with 8'h55 -> err_cnt=1, locked stays 1, pass=0. With SEQ_CHK_CAPTURE_EN: first_exp=8'h40, first_act=8'h55, first_vld=1.
- Slip: locked, skip one value permanently (jump +2) -> err_cnt=LOSS_CNT (8), locked falls, lost=1, relock after LOCK_CNT matches, err_cnt stays 8.
- Saturation/clr: ERR_W=2, constant data 8'h00 while locked (LOSS_CNT=8) -> err_cnt saturates at 3. Assert clr in same cycle as a mismatch -> err_cnt=0, lost=0, chk_cnt=0.
- Reset mid-operation: assert rst_n=0 while LOCKED with err_cnt=5 -> all outputs 0 immediately (asynchronous). Release -> IDLE; re-acquire only with en=1.

Source files
------------

// File: rtl/tt_factory_seq_checker.sv
// Purpose : locks onto an 8-bit free-running up/down counter bus, then counts per-cycle deviations.
// Latency : status registered one edge after the deciding sample; pass is combinational from registers.
// Backpressure: none; a pure observer that samples every enabled cycle and never stalls or drives the source.
//
// Ports: clk/rst_n (async active-low); en (low forces IDLE); dir (1 = +1, 0 = -1);
//        clr (sync clear of err_cnt/chk_cnt/lost/capture); data_in (observed bus);
//        locked, pass, lost, err_cnt[ERR_W], chk_cnt[16]; first_exp/first_act/first_vld.
// Build option: define SEQ_CHK_CAPTURE_EN to capture the first LOCKED mismatch
//        (expected/observed) on first_exp/first_act/first_vld; otherwise those ports read 0.
module tt_factory_seq_checker #(
  parameter int LOCK_CNT = 4,   // consecutive good steps to lock (1..15)
  parameter int LOSS_CNT = 8,   // consecutive misses in LOCKED to re-acquire (1..255)
  parameter int ERR_W    = 8    // saturating error counter width
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  input  logic [7:0]       data_in,
  output logic             locked,
  output logic             pass,
  output logic             lost,
  output logic [ERR_W-1:0] err_cnt,
  output logic [15:0]      chk_cnt,
  output logic [7:0]       first_exp,
  output logic [7:0]       first_act,
  output logic             first_vld
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_LAST = 4'(LOCK_CNT - 1);
  localparam logic [7:0] LOSS_LAST = 8'(LOSS_CNT - 1);

  state_t     state, state_nxt;
  logic [7:0] expected;
  logic       seeded;      // first ACQUIRE sample only seeds the prediction
  logic [3:0] match_run;
  logic [7:0] miss_run;
  logic [7:0] step;
  logic       hit;
  logic       lock_hit;
  logic       loss_hit;
  logic       chk_act;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    step      = dir ? 8'h01 : 8'hFF;   // modulo-256 step, wrap is a correct step
    hit       = (data_in == expected);
    chk_act   = en && (state == S_LOCKED);
    lock_hit  = 1'b0;
    loss_hit  = 1'b0;
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (en) state_nxt = S_ACQUIRE;
      end
      S_ACQUIRE: begin
        lock_hit = seeded && hit && (match_run == LOCK_LAST);
        if (lock_hit) state_nxt = S_LOCKED;
      end
      S_LOCKED: begin
        loss_hit = !hit && (miss_run == LOSS_LAST);
        if (loss_hit) state_nxt = S_ACQUIRE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (!en) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Prediction and run counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expected  <= 8'h00;
      seeded    <= 1'b0;
      match_run <= 4'd0;
      miss_run  <= 8'd0;
    end else if (!en) begin
      seeded    <= 1'b0;
      match_run <= 4'd0;
      miss_run  <= 8'd0;
    end else begin
      case (state)
        S_ACQUIRE: begin
          // Seed, match and mismatch all re-predict from the observed sample.
          expected <= data_in + step;
          seeded   <= 1'b1;
          if (seeded && hit && !lock_hit) match_run <= match_run + 4'd1;
          else                            match_run <= 4'd0;
        end
        S_LOCKED: begin
          // Flywheel: the prediction free-runs and ignores data_in.
          expected <= expected + step;
          if (hit || loss_hit) miss_run <= 8'd0;
          else                 miss_run <= miss_run + 8'd1;
          if (loss_hit) seeded <= 1'b0;
        end
        default: begin
          seeded    <= 1'b0;
          match_run <= 4'd0;
          miss_run  <= 8'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Status counters; clr beats any coincident increment
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
      chk_cnt <= 16'h0000;
      lost    <= 1'b0;
    end else if (clr) begin
      err_cnt <= '0;
      chk_cnt <= 16'h0000;
      lost    <= 1'b0;
    end else if (chk_act) begin
      if (chk_cnt != 16'hFFFF) chk_cnt <= chk_cnt + 16'd1;
      if (!hit && (err_cnt != {ERR_W{1'b1}})) err_cnt <= err_cnt + 1'b1;
      if (loss_hit) lost <= 1'b1;
    end
  end

  assign locked = (state == S_LOCKED);
  assign pass   = locked && (err_cnt == '0) && !lost;

`ifdef SEQ_CHK_CAPTURE_EN
  // First LOCKED mismatch since reset/clr is frozen until the next clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_exp <= 8'h00;
      first_act <= 8'h00;
      first_vld <= 1'b0;
    end else if (clr) begin
      first_exp <= 8'h00;
      first_act <= 8'h00;
      first_vld <= 1'b0;
    end else if (chk_act && !hit && !first_vld) begin
      first_exp <= expected;
      first_act <= data_in;
      first_vld <= 1'b1;
    end
  end
`else
  assign first_exp = 8'h00;
  assign first_act = 8'h00;
  assign first_vld = 1'b0;
`endif

endmodule
